multi_blaster: RTL

MULTI_BLASTER -- requirements
Module: multi_blaster

---
 rtl/multi_blaster.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_blaster.sv
// multi_blaster: capacitor-discharge igniter controller.
// Charges a storage capacitor, waits for a fire command and then drives a
// hysteretic current regulator on one selected igniter channel. It watches
// for burnout, overcurrent and capacitor undervoltage during the burn.
module multi_blaster #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned ADC_W          = 12,
  parameter int unsigned DEBOUNCE       = 64,
  parameter int unsigned CHARGE_TIMEOUT = 32'd16777216,
  parameter int unsigned FIRE_TIMEOUT   = 32'd1048576,
  parameter int unsigned BURN_V         = 800,
  parameter int unsigned BURN_I         = 12,
  parameter int unsigned OCP_I          = 3840,
  parameter int unsigned UV_V           = 48
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       arm_button,
  input  logic                                       fire_button,
  input  logic                                       charge_done,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
  input  logic                                       adc_valid,
  input  logic [ADC_W-1:0]                           vcap,
  input  logic [ADC_W-1:0]                           icap,
  input  logic [N_CH*ADC_W-1:0]                      vout,
  input  logic [N_CH*ADC_W-1:0]                      iout,
  input  logic [2:0]                                 iset,
  output logic                                       charge_en,
  output logic                                       dump,
  output logic [N_CH-1:0]                            pwm,
  output logic                                       arm_led,
  output logic [2:0]                                 state,
  output logic [1:0]                                 fault
);

  localparam int unsigned SW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CCW = (CHARGE_TIMEOUT > 1) ? $clog2(CHARGE_TIMEOUT) : 1;
  localparam int unsigned FCW = (FIRE_TIMEOUT > 1) ? $clog2(FIRE_TIMEOUT) : 1;
  localparam int unsigned DBW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int unsigned BLW = 24;

  localparam logic [CCW-1:0]   CHG_LAST  = CCW'(CHARGE_TIMEOUT - 1);
  localparam logic [FCW-1:0]   FIRE_LAST = FCW'(FIRE_TIMEOUT - 1);
  localparam logic [DBW-1:0]   DB_LOAD   = DBW'(DEBOUNCE);
  localparam logic [ADC_W-1:0] BURN_V_C  = ADC_W'(BURN_V);
  localparam logic [ADC_W-1:0] BURN_I_C  = ADC_W'(BURN_I);
  localparam logic [ADC_W-1:0] OCP_I_C   = ADC_W'(OCP_I);
  localparam logic [ADC_W-1:0] UV_V_C    = ADC_W'(UV_V);

  localparam logic [1:0] FLT_NONE   = 2'd0;
  localparam logic [1:0] FLT_OCP    = 2'd1;
  localparam logic [1:0] FLT_CHG_TO = 2'd2;
  localparam logic [1:0] FLT_BADCH  = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHARGE    = 3'd1,
    READY     = 3'd2,
    FIRE      = 3'd3,
    DISCHARGE = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      fault_q, fault_d;
  logic [N_CH-1:0] pwm_q, pwm_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CCW-1:0]  chg_cnt_q, chg_cnt_d;
  logic [FCW-1:0]  fire_cnt_q, fire_cnt_d;
  logic [DBW-1:0]  db_q, db_d;
  logic [BLW-1:0]  blink_q, blink_d;
  logic            charge_en_q, charge_en_d;
  logic            dump_q, dump_d;
  logic            arm_led_q, arm_led_d;

  logic [ADC_W-1:0] v_sel, i_sel;
  logic             p_sel;
  logic [ADC_W-1:0] nominal, lower, upper;
  logic             ch_ok, burnout, db_expired, pwm_bit;

  // Select the telemetry and current pwm level of the latched channel.
  always_comb begin
    v_sel = '0;
    i_sel = '0;
    p_sel = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel_q == SW'(k)) begin
        v_sel = vout[k*ADC_W +: ADC_W];
        i_sel = iout[k*ADC_W +: ADC_W];
        p_sel = pwm_q[k];
      end
    end
  end

  // Regulation window around the requested current, plus status decodes.
  always_comb begin
    nominal    = ADC_W'(iset) << (ADC_W - 4);
    lower      = nominal - (nominal >> 3);
    upper      = nominal + (nominal >> 3);
    ch_ok      = (32'(ch_sel) < N_CH);
    burnout    = (v_sel >= BURN_V_C) && (i_sel <= BURN_I_C);
    db_expired = (db_q == '0);
  end

  // Next-state, fault, channel latch and per-state counters.
  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    sel_d      = sel_q;
    chg_cnt_d  = chg_cnt_q;
    fire_cnt_d = fire_cnt_q;
    db_d       = db_q;
    blink_d    = blink_q;

    case (state_q)
      IDLE: begin
        if (arm_button) state_d = CHARGE;
      end
      CHARGE: begin
        if (!arm_button) begin
          state_d = IDLE;
        end else if (chg_cnt_q == CHG_LAST) begin
          state_d = FAULT;
          fault_d = FLT_CHG_TO;
        end else if (charge_done) begin
          state_d = READY;
        end
      end
      READY: begin
        if (!arm_button) begin
          state_d = IDLE;
        end else if (fire_button) begin
          if (ch_ok) begin
            state_d = FIRE;
            sel_d   = ch_sel;
          end else begin
            state_d = FAULT;
            fault_d = FLT_BADCH;
          end
        end
      end
      FIRE: begin
        // Order matters: a release or burnout ends the burn cleanly even if
        // the same sample would also trip overcurrent.
        if (db_expired && !fire_button) begin
          state_d = DISCHARGE;
        end else if (fire_cnt_q == FIRE_LAST) begin
          state_d = DISCHARGE;
        end else if (adc_valid && burnout) begin
          state_d = DISCHARGE;
        end else if (adc_valid && (icap >= OCP_I_C)) begin
          state_d = FAULT;
          fault_d = FLT_OCP;
        end else if (adc_valid && (vcap < UV_V_C)) begin
          state_d = DISCHARGE;
        end
      end
      DISCHARGE, FAULT: begin
        if (!arm_button) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) fault_d = FLT_NONE;

    if (state_d == CHARGE) begin
      chg_cnt_d = (state_q == CHARGE) ? chg_cnt_q + 1'b1 : '0;
      blink_d   = (state_q == CHARGE) ? blink_q + 1'b1 : '0;
    end

    if (state_d == FIRE) begin
      if (state_q == FIRE) begin
        fire_cnt_d = fire_cnt_q + 1'b1;
        db_d       = db_expired ? '0 : db_q - 1'b1;
      end else begin
        fire_cnt_d = '0;
        db_d       = DB_LOAD;
      end
    end
  end

  // Hysteretic regulator on the selected channel; all other bits stay low.
  always_comb begin
    pwm_bit = p_sel;
    if (adc_valid) begin
      if (!p_sel && (i_sel <= lower)) pwm_bit = 1'b1;
      else if (p_sel && (i_sel >= upper)) pwm_bit = 1'b0;
    end
    pwm_d = '0;
    if ((state_q == FIRE) && (state_d == FIRE)) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        pwm_d[k] = (sel_q == SW'(k)) ? pwm_bit : 1'b0;
      end
    end
  end

  // Status outputs decoded from the upcoming state so they register with it.
  always_comb begin
    charge_en_d = (state_d == CHARGE) || (state_d == READY);
    dump_d      = (state_d == DISCHARGE);
    arm_led_d   = (state_d == READY) || (state_d == FIRE) ||
                  ((state_d == CHARGE) && blink_d[BLW-1]);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fault_q     <= FLT_NONE;
      pwm_q       <= '0;
      sel_q       <= '0;
      chg_cnt_q   <= '0;
      fire_cnt_q  <= '0;
      db_q        <= '0;
      blink_q     <= '0;
      charge_en_q <= 1'b0;
      dump_q      <= 1'b0;
      arm_led_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      pwm_q       <= pwm_d;
      sel_q       <= sel_d;
      chg_cnt_q   <= chg_cnt_d;
      fire_cnt_q  <= fire_cnt_d;
      db_q        <= db_d;
      blink_q     <= blink_d;
      charge_en_q <= charge_en_d;
      dump_q      <= dump_d;
      arm_led_q   <= arm_led_d;
    end
  end

  assign state     = state_q;
  assign fault     = fault_q;
  assign pwm       = pwm_q;
  assign charge_en = charge_en_q;
  assign dump      = dump_q;
  assign arm_led   = arm_led_q;

endmodule
